// File: rtl/prio_sched_pkg.sv
// Shared types and helpers for the priority request scheduler.
// Optional mask support is enabled with PRIO_SCHED_MASK_EN.
package prio_sched_pkg;

    localparam int PRIO_WIDTH_DEFAULT = 8;
    localparam int PRIO_WIDTH_MAX     = 32;

    function automatic logic [PRIO_WIDTH_MAX-1:0] onehot(
        input logic [4:0] idx
    );
        return {{(PRIO_WIDTH_MAX-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [5:0] popcount(
        input logic [PRIO_WIDTH_MAX-1:0] vec
    );
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < PRIO_WIDTH_MAX; i++)
            n = n + {5'd0, vec[i]};
        return n;
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational MSB-first priority encoder.
// Used by prio_req_scheduler (PRIO_SCHED_MASK_EN aware at the top level).
module prio_enc_comb
    import prio_sched_pkg::*;
#(
    parameter int WIDTH = PRIO_WIDTH_DEFAULT,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan: the last hit, i.e. the highest set bit, wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (vec[i])
                idx = IDX_W'(i);
    end

    assign any = |vec;

endmodule

// File: rtl/prio_req_scheduler.sv
// Sticky request capture with registered MSB-first index and valid/ready.
// Define PRIO_SCHED_MASK_EN to add the mask_in eligibility port.
module prio_req_scheduler
    import prio_sched_pkg::*;
#(
    parameter int WIDTH = PRIO_WIDTH_DEFAULT,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PRIO_SCHED_MASK_EN
    input  logic [WIDTH-1:0] mask_in,
`endif
    output logic [WIDTH-1:0] pending,
    output logic [IDX_W:0]   pending_cnt
);

    logic                      fire;
    logic [PRIO_WIDTH_MAX-1:0] oh_full;
    logic [PRIO_WIDTH_MAX-1:0] cnt_in;
    logic [5:0]                cnt_full;
    logic [WIDTH-1:0]          clr_vec;
    logic [WIDTH-1:0]          pending_next;
    logic [WIDTH-1:0]          enc_in;
    logic [IDX_W-1:0]          enc_idx;
    logic                      enc_any;

    assign fire = out_valid & out_ready;

    always_comb begin
        oh_full = onehot(5'(out_idx));
        clr_vec = fire ? oh_full[WIDTH-1:0] : '0;
        // Set wins over clear so a re-asserted line is re-issued later.
        pending_next = (pending & ~clr_vec) | req_in;
`ifdef PRIO_SCHED_MASK_EN
        enc_in = pending & ~clr_vec & ~mask_in;
`else
        enc_in = pending & ~clr_vec;
`endif
        cnt_in   = PRIO_WIDTH_MAX'(pending_next);
        cnt_full = popcount(cnt_in);
    end

    prio_enc_comb #(
        .WIDTH (WIDTH)
    ) u_enc (
        .vec (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
            out_valid   <= 1'b0;
            out_idx     <= '0;
        end else begin
            pending     <= pending_next;
            pending_cnt <= cnt_full[IDX_W:0];
            // Presented index holds under backpressure; no pre-emption.
            if (!out_valid || fire) begin
                out_valid <= enc_any;
                out_idx   <= enc_idx;
            end
        end
    end

endmodule

// File: tb/tb_prio_req_scheduler.sv
// Directed bench for prio_req_scheduler with an index scoreboard.
// Covers the mask_in path when PRIO_SCHED_MASK_EN is defined.
module tb_prio_req_scheduler;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] req_in;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pending;
    logic [IDX_W:0]   pending_cnt;
`ifdef PRIO_SCHED_MASK_EN
    logic [WIDTH-1:0] mask_in;
`endif

    int tests;
    int fails;
    logic [IDX_W-1:0] exp_q[$];

    prio_req_scheduler #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .out_idx     (out_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef PRIO_SCHED_MASK_EN
        .mask_in     (mask_in),
`endif
        .pending     (pending),
        .pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted index must match the next expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_fire", 32'(out_idx), 32'hFFFF_FFFF);
            end else begin
                chk("sb_idx", 32'(out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_in    = '0;
        out_ready = 1'b0;
`ifdef PRIO_SCHED_MASK_EN
        mask_in   = '0;
`endif
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_cnt", 32'(pending_cnt), 32'd0);
        rst_n = 1'b1;

        // Reset mid-transfer
        req_in = 8'hA0;
        tick();
        req_in = '0;
        tick();
        chk("t1_valid_pre", 32'(out_valid), 32'd1);
        chk("t1_idx_pre", 32'(out_idx), 32'd7);
        chk("t1_pend_pre", 32'(pending), 32'hA0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t1_valid_rst", 32'(out_valid), 32'd0);
        chk("t1_pend_rst", 32'(pending), 32'd0);
        chk("t1_cnt_rst", 32'(pending_cnt), 32'd0);
        req_in = 8'h02;
        tick();
        req_in = '0;
        chk("t1_recapture", 32'(pending), 32'h02);
        exp_q.push_back(3'd1);
        out_ready = 1'b1;
        tick();
        chk("t1_idx", 32'(out_idx), 32'd1);
        tick();
        chk("t1_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Single request latency
        req_in = 8'h04;
        tick();
        req_in = '0;
        chk("t2_pend", 32'(pending), 32'h04);
        chk("t2_valid_n", 32'(out_valid), 32'd0);
        tick();
        chk("t2_valid_n1", 32'(out_valid), 32'd1);
        chk("t2_idx", 32'(out_idx), 32'd2);
        exp_q.push_back(3'd2);
        out_ready = 1'b1;
        tick();
        chk("t2_pend_clr", 32'(pending), 32'd0);
        chk("t2_valid_clr", 32'(out_valid), 32'd0);

        // Priority drain
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd4);
        exp_q.push_back(3'd0);
        req_in = 8'h91;
        tick();
        req_in = '0;
        chk("t3_cnt0", 32'(pending_cnt), 32'd3);
        tick();
        chk("t3_idx7", 32'(out_idx), 32'd7);
        chk("t3_cnt3", 32'(pending_cnt), 32'd3);
        tick();
        chk("t3_idx4", 32'(out_idx), 32'd4);
        chk("t3_cnt2", 32'(pending_cnt), 32'd2);
        tick();
        chk("t3_idx0", 32'(out_idx), 32'd0);
        chk("t3_cnt1", 32'(pending_cnt), 32'd1);
        tick();
        chk("t3_cnt_end", 32'(pending_cnt), 32'd0);
        chk("t3_valid_end", 32'(out_valid), 32'd0);

        // Backpressure hold
        out_ready = 1'b0;
        req_in = 8'h08;
        tick();
        req_in = '0;
        tick();
        chk("t4_idx3", 32'(out_idx), 32'd3);
        req_in = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_in = '0;
            chk("t4_hold_idx", 32'(out_idx), 32'd3);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
        end
        chk("t4_pend", 32'(pending), 32'h88);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd7);
        out_ready = 1'b1;
        tick();
        chk("t4_next7", 32'(out_idx), 32'd7);
        tick();
        chk("t4_drained", 32'(out_valid), 32'd0);

        // Set-wins collision
        out_ready = 1'b0;
        req_in = 8'h21;
        tick();
        req_in = '0;
        tick();
        chk("t5_idx5", 32'(out_idx), 32'd5);
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd5);
        out_ready = 1'b1;
        req_in = 8'h20;
        tick();
        req_in = '0;
        chk("t5_pend5", 32'(pending[5]), 32'd1);
        chk("t5_idx0", 32'(out_idx), 32'd0);
        tick();
        chk("t5_reissue", 32'(out_idx), 32'd5);
        chk("t5_reissue_v", 32'(out_valid), 32'd1);
        tick();
        chk("t5_drained", 32'(pending), 32'd0);

        // All bits set
        out_ready = 1'b0;
        req_in = 8'hFF;
        tick();
        req_in = '0;
        chk("all_cnt", 32'(pending_cnt), 32'd8);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back(IDX_W'(i));
        out_ready = 1'b1;
        repeat (9) tick();
        chk("all_cnt_end", 32'(pending_cnt), 32'd0);
        chk("all_valid_end", 32'(out_valid), 32'd0);

`ifdef PRIO_SCHED_MASK_EN
        // Masked bits count but are not presented
        out_ready = 1'b0;
        mask_in = 8'h80;
        req_in = 8'hC0;
        tick();
        req_in = '0;
        tick();
        chk("t6_idx6", 32'(out_idx), 32'd6);
        chk("t6_cnt2", 32'(pending_cnt), 32'd2);
        exp_q.push_back(3'd6);
        exp_q.push_back(3'd7);
        out_ready = 1'b1;
        tick();
        chk("t6_masked_idle", 32'(out_valid), 32'd0);
        mask_in = '0;
        tick();
        chk("t6_idx7", 32'(out_idx), 32'd7);
        chk("t6_valid7", 32'(out_valid), 32'd1);
        tick();
        chk("t6_drained", 32'(pending), 32'd0);
`endif

        out_ready = 1'b0;
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
